// File: rtl/fa_pkg.sv
// Shared definitions for the full-adder response checker: FSM states,
// the golden full-adder model and code-space constants.
package fa_pkg;

    localparam int FA_CODES = 8;
    localparam int CODE_W   = $clog2(FA_CODES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fa_state_t;

    // Returns {cout, s} for one full-adder evaluation.
    function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/fa_delay_line.sv
// LATENCY-deep valid/code shift register with synchronous flush; a plain
// wire-through when LATENCY is 0.
module fa_delay_line
    import fa_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_vld,
    output logic [CODE_W-1:0] out_code
);

    if (LATENCY == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, flush};
        assign out_vld   = in_vld;
        assign out_code  = in_code;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_q;
        logic [CODE_W-1:0]  code_q [LATENCY];

        // NOTE: the line is only a few entries deep, so every stage (data too)
        // is reset; this keeps the reset state fully defined.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY; i++) code_q[i] <= '0;
            end else if (flush) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY; i++) code_q[i] <= '0;
            end else begin
                vld_q[0]  <= in_vld;
                code_q[0] <= in_code;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    code_q[i] <= code_q[i-1];
                end
            end
        end

        assign out_vld  = vld_q[LATENCY-1];
        assign out_code = code_q[LATENCY-1];
    end

endmodule

// File: rtl/fa_response_checker.sv
// Full-adder response checker: aligns stimulus with the DUT response,
// compares against the golden model and tracks coverage of all 8 codes.
module fa_response_checker
    import fa_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vld,
    input  logic              a,
    input  logic              b,
    input  logic              cin,
    input  logic              cout,
    input  logic              s,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [FA_CODES-1:0] coverage,
    output logic [CODE_W-1:0] first_err_vec,
    output logic              first_err_vld
);

    fa_state_t         state;
    logic              flush;
    logic              dl_vld;
    logic [CODE_W-1:0] dl_code;
    logic              cmp;
    logic              mismatch;

    // Outside RUN the line is held empty, which also drops entries still in
    // flight when the sweep completes; a start flushes it for the new session.
    assign flush = start || (state != RUN);

    fa_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_vld   (vld),
        .in_code  ({a, b, cin}),
        .out_vld  (dl_vld),
        .out_code (dl_code)
    );

    // A start in the same cycle discards the compare.
    assign cmp      = (state == RUN) && dl_vld && !start;
    assign mismatch = cmp && ({cout, s} != fa_golden(dl_code[2], dl_code[1], dl_code[0]));

    // NOTE: all state here is sequential, so only non-blocking assignments
    // are used; reads within the block see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            err_cnt       <= '0;
            coverage      <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
        end else if (start) begin
            state         <= RUN;
            err_cnt       <= '0;
            coverage      <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
        end else if (state == RUN) begin
            if (&coverage) state <= DONE;
            if (cmp) coverage[dl_code] <= 1'b1;
            if (mismatch) begin
                if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
                if (!first_err_vld) begin
                    first_err_vec <= dl_code;
                    first_err_vld <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench: four checker instances (different LATENCY/ERR_W) share one
// stimulus; a behavioural full adder with selectable faults supplies responses.
module tb_fa_response_checker;

    logic clk = 1'b0;
    logic rst, start, vld, a, b, cin;
    int   mode;          // 0 correct, 1 s stuck at 0, 2 both outputs inverted
    int   passed = 0;
    int   total  = 0;
    int   edges;

    always #5 clk = ~clk;

    // Stimulus history so each instance sees a response matching its latency.
    logic [2:0] st_d1, st_d2, st_d3;
    always @(posedge clk) begin
        st_d1 <= {a, b, cin};
        st_d2 <= st_d1;
        st_d3 <= st_d2;
    end

    function automatic logic [1:0] resp(input logic [2:0] code, input int m);
        logic [1:0] sum;
        sum = 2'(code[2]) + 2'(code[1]) + 2'(code[0]);
        case (m)
            1:       return {sum[1], 1'b0};
            2:       return ~sum;
            default: return sum;
        endcase
    endfunction

    logic [1:0] r0, r2, r3;
    assign r0 = resp({a, b, cin}, mode);
    assign r2 = resp(st_d2, mode);
    assign r3 = resp(st_d3, mode);

    logic       busy0, done0, pass0, fev0;
    logic [7:0] err0, cov0;
    logic [2:0] fe0;
    logic       busy2, done2, pass2, fev2;
    logic [7:0] err2, cov2;
    logic [2:0] fe2;
    logic       busyw, donew, passw, fevw;
    logic [1:0] errw;
    logic [7:0] covw;
    logic [2:0] few;
    logic       busy3, done3, pass3, fev3;
    logic [7:0] err3, cov3;
    logic [2:0] fe3;

    fa_response_checker #(.LATENCY(0), .ERR_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
        .cout(r0[1]), .s(r0[0]), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .coverage(cov0), .first_err_vec(fe0), .first_err_vld(fev0));

    fa_response_checker #(.LATENCY(2), .ERR_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
        .cout(r2[1]), .s(r2[0]), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .coverage(cov2), .first_err_vec(fe2), .first_err_vld(fev2));

    fa_response_checker #(.LATENCY(0), .ERR_W(2)) uw (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
        .cout(r0[1]), .s(r0[0]), .busy(busyw), .done(donew), .pass(passw),
        .err_cnt(errw), .coverage(covw), .first_err_vec(few), .first_err_vld(fevw));

    fa_response_checker #(.LATENCY(3), .ERR_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
        .cout(r3[1]), .s(r3[0]), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .coverage(cov3), .first_err_vec(fe3), .first_err_vld(fev3));

    // All drive tasks are entered and left just after a falling edge.
    task automatic send(input logic [2:0] code);
        vld = 1'b1;
        {a, b, cin} = code;
        @(negedge clk);
        edges++;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        vld   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if ({busy0, done0, pass0, fev0} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {busy0, done0, pass0, fev0}); else passed++;
        total++; if (err0 !== 8'd0) $display("FAIL reset_err got %0d exp 0", err0); else passed++;
        total++; if (cov0 !== 8'h00) $display("FAIL reset_cov got %h exp 00", cov0); else passed++;
        total++; if ({busy3, done3, err3, cov3} !== 18'd0) $display("FAIL reset_l3 got %h exp 0", {busy3, done3, err3, cov3}); else passed++;
        rst = 1'b0;
        mode = 1;
        for (int i = 0; i < 8; i++) send(3'(i));
        idle(4);
        total++; if (cov3 !== 8'h00 || cov0 !== 8'h00) $display("FAIL idle_vld_cov got %h/%h exp 00/00", cov0, cov3); else passed++;
        total++; if (busy0 !== 1'b0 || err0 !== 8'd0) $display("FAIL idle_vld_state got busy=%b err=%0d exp busy=0 err=0", busy0, err0); else passed++;
    endtask

    task automatic test_correct_sweep();
        mode = 0;
        pulse_start();
        total++; if (busy0 !== 1'b1) $display("FAIL sweep_busy got %b exp 1", busy0); else passed++;
        for (int i = 0; i < 8; i++) send(3'(i));
        vld = 1'b0;
        total++; if (cov0 !== 8'hFF || done0 !== 1'b0) $display("FAIL sweep_cov got cov=%h done=%b exp cov=ff done=0", cov0, done0); else passed++;
        while (!done0 && edges < 40) idle(1);
        total++; if (edges !== 9) $display("FAIL sweep_done_cycle got %0d exp 9", edges); else passed++;
        total++; if (pass0 !== 1'b1 || err0 !== 8'd0) $display("FAIL sweep_pass got pass=%b err=%0d exp pass=1 err=0", pass0, err0); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL sweep_busy_end got %b exp 0", busy0); else passed++;
    endtask

    task automatic test_stuck_s_lat2();
        mode = 1;
        pulse_start();
        for (int i = 0; i < 8; i++) send(3'(i));
        while (!done2 && edges < 40) idle(1);
        total++; if (done2 !== 1'b1) $display("FAIL stuck_done got %b exp 1", done2); else passed++;
        total++; if (err2 !== 8'd4) $display("FAIL stuck_err got %0d exp 4", err2); else passed++;
        total++; if (fe2 !== 3'd1 || fev2 !== 1'b1) $display("FAIL stuck_first got vec=%0d vld=%b exp vec=1 vld=1", fe2, fev2); else passed++;
        total++; if (pass2 !== 1'b0 || cov2 !== 8'hFF) $display("FAIL stuck_pass got pass=%b cov=%h exp pass=0 cov=ff", pass2, cov2); else passed++;
    endtask

    task automatic test_partial_sweep();
        mode = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) send(3'(i));
        idle(3);
        total++; if (busy0 !== 1'b1 || done0 !== 1'b0) $display("FAIL partial_state got busy=%b done=%b exp busy=1 done=0", busy0, done0); else passed++;
        total++; if (cov0 !== 8'h7F) $display("FAIL partial_cov got %h exp 7f", cov0); else passed++;
        send(3'd7);
        vld = 1'b0;
        total++; if (cov0 !== 8'hFF || done0 !== 1'b0) $display("FAIL partial_last got cov=%h done=%b exp cov=ff done=0", cov0, done0); else passed++;
        idle(1);
        total++; if (done0 !== 1'b1 || pass0 !== 1'b1) $display("FAIL partial_done got done=%b pass=%b exp 1 1", done0, pass0); else passed++;
    endtask

    task automatic test_saturate();
        mode = 2;
        pulse_start();
        for (int i = 0; i < 3; i++) send(3'(i));
        total++; if (errw !== 2'd3 || err0 !== 8'd3) $display("FAIL sat_three got %0d/%0d exp 3/3", errw, err0); else passed++;
        for (int i = 3; i < 12; i++) send(3'(i % 4));
        vld = 1'b0;
        total++; if (errw !== 2'd3) $display("FAIL sat_hold got %0d exp 3", errw); else passed++;
        total++; if (err0 !== 8'd12) $display("FAIL sat_wide got %0d exp 12", err0); else passed++;
        total++; if (few !== 3'd0 || fevw !== 1'b1 || busyw !== 1'b1) $display("FAIL sat_first got vec=%0d vld=%b busy=%b exp 0 1 1", few, fevw, busyw); else passed++;
        total++; if (covw !== 8'h0F) $display("FAIL sat_cov got %h exp 0f", covw); else passed++;
    endtask

    task automatic test_restart_lat3();
        logic [2:0] seq [7];
        seq = '{3'd0, 3'd3, 3'd5, 3'd1, 3'd2, 3'd4, 3'd7};
        mode = 1;
        pulse_start();
        for (int i = 0; i < 7; i++) send(seq[i]);
        total++; if (err3 !== 8'd1 || cov3 !== 8'h2B) $display("FAIL restart_pre got err=%0d cov=%h exp err=1 cov=2b", err3, cov3); else passed++;
        total++; if (fev3 !== 1'b1 || fe3 !== 3'd1) $display("FAIL restart_pre_first got vld=%b vec=%0d exp 1 1", fev3, fe3); else passed++;
        pulse_start();
        total++; if (err3 !== 8'd0 || cov3 !== 8'h00 || fev3 !== 1'b0) $display("FAIL restart_clear got err=%0d cov=%h fev=%b exp 0 00 0", err3, cov3, fev3); else passed++;
        idle(5);
        total++; if (err3 !== 8'd0 || cov3 !== 8'h00 || busy3 !== 1'b1) $display("FAIL restart_inflight got err=%0d cov=%h busy=%b exp 0 00 1", err3, cov3, busy3); else passed++;
        mode = 0;
        for (int i = 0; i < 8; i++) send(3'(7 - i));
        while (!done3 && edges < 60) idle(1);
        total++; if (done3 !== 1'b1 || pass3 !== 1'b1 || err3 !== 8'd0) $display("FAIL restart_sweep got done=%b pass=%b err=%0d exp 1 1 0", done3, pass3, err3); else passed++;
    endtask

    task automatic test_async_reset();
        mode = 1;
        pulse_start();
        send(3'd1);
        send(3'd2);
        total++; if (err0 !== 8'd2 || busy0 !== 1'b1) $display("FAIL areset_pre got err=%0d busy=%b exp 2 1", err0, busy0); else passed++;
        vld = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({busy0, done0, pass0, fev0, fe0} !== 7'd0) $display("FAIL areset_flags got %b exp 0000000", {busy0, done0, pass0, fev0, fe0}); else passed++;
        total++; if (err0 !== 8'd0 || cov0 !== 8'h00) $display("FAIL areset_results got err=%0d cov=%h exp 0 00", err0, cov0); else passed++;
        @(negedge clk);
        rst = 1'b0;
        send(3'd4);
        send(3'd7);
        idle(4);
        total++; if (busy0 !== 1'b0 || cov0 !== 8'h00 || err0 !== 8'd0 || cov3 !== 8'h00) $display("FAIL areset_idle got busy=%b cov=%h err=%0d cov3=%h exp 0 00 0 00", busy0, cov0, err0, cov3); else passed++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        vld   = 1'b0;
        {a, b, cin} = 3'd0;
        mode  = 0;
        edges = 0;
        test_reset();
        test_correct_sweep();
        test_stuck_s_lat2();
        test_partial_sweep();
        test_saturate();
        test_restart_lat3();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
